dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the multi-cycle core variant: the target end of the load/store interface that the core drives. It accepts one request at a time over a valid/ready request channel, commits byte-masked stores, and returns read data with a configurable latency over a valid/ready response channel. It replaces the combinational data memory when the core needs realistic memory wait states.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words, power of two, 4..65536
- LATENCY, 2: cycles from request acceptance to `rsp_valid`, 1..15

- clk  in  1  rising-edge clock; the block has one clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  store byte enables; bit i covers bits 8i+7:8i
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts the response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP. At most one request is outstanding.
- IDLE: `req_ready`=1. When `req_valid && req_ready`, the request is accepted. The block latches `req_we` and the word index. It loads the wait counter with LATENCY-1 and moves to WAIT. If LATENCY=1, it moves straight to RESP.
- Error check at acceptance: `req_addr[1:0]`≠0, or `req_addr[31:2]` ≥ DEPTH_WORDS. Either condition sets the latched error flag.
- Store commit: the array is written on the accepting clock edge. Only bytes with `req_be` set are written, and only when there is no error. `req_be`=0 is a legal no-op and still produces a response.
- Load: the word is read from the latched index during the last WAIT cycle (or at acceptance when LATENCY=1). It is registered into `rsp_rdata` on entry to RESP. `req_be` is ignored.
- WAIT: `req_ready`=0. The counter decrements each cycle. At 0 the block moves to RESP.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` stay stable until `rsp_ready`=1. On that handshake the block moves to IDLE. `rsp_valid` falls on the next edge, and `req_ready` rises on the same edge.
- For an error response: `rsp_err`=1, `rsp_rdata`=0, and the array is unchanged.
- For a store response: `rsp_rdata`=0.
- Inputs on the request channel are ignored whenever `req_ready`=0.
- Array contents are not reset.

## Timing
- Reset values while `rst`=1 on an edge: state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- `req_ready`=1 from the first cycle after `rst` deasserts.
- Latency: a request accepted at edge N gives `rsp_valid` high in the cycle after edge N+LATENCY-1. The response is therefore visible LATENCY cycles after acceptance, regardless of whether it is a load or a store.
- Minimum request-to-request spacing is LATENCY+1 cycles when `rsp_ready` is held at 1. There is no same-cycle overlap of a response handshake and a new request acceptance.
- Read-after-write: a load accepted after a store's response sees the stored bytes.
- Reset mid-operation (in WAIT or RESP): the pending response is dropped and the block returns to IDLE. A store already committed at acceptance remains in the array.
- Counter width: 4 bits. Index width: log2(DEPTH_WORDS) bits. Range comparison uses all 30 upper address bits, so no aliasing is allowed.

## Test plan
- Reset, then a store to addr 0x10 with wdata 0xDEADBEEF and be=1111, followed by a load from 0x10 (LATENCY=2). Each `rsp_valid` must rise exactly 2 cycles after acceptance. The load must return 0xDEADBEEF with err=0.
- Partial store with be=0101 and wdata 0x11223344 to a word holding 0xDEADBEEF. A following load must return 0xDE22BE44.
- Load from addr 0x13. Then a store to addr 4*DEPTH_WORDS. Both must give err=1 and rdata=0. The store must not modify any word, which is checked by reading back word 0 and the last word.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises. `rsp_rdata`/`rsp_err` must stay stable and `req_ready` must stay 0 throughout. `req_ready` must return to 1 on the cycle after the handshake.
- Assert `rst` for 1 cycle while in WAIT after a store. No response may appear, and `req_ready`=1 the cycle after reset. A later load must return the stored data.
- Run with LATENCY=1 and a load of a known value with `rsp_ready` tied high. `rsp_valid` must appear 1 cycle after acceptance, and back-to-back requests must be accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with valid/ready request and response channels
//
// Purpose: target end of the core's load/store interface. Accepts one request at a
// time, commits byte-masked stores on the accepting edge, and returns a response
// LATENCY cycles after acceptance.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we, req_addr         1 = store / 0 = load, byte address
//   req_wdata, req_be        store data and byte enables (bit i -> bits 8i+7:8i)
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_err       load data (0 for stores and errors), access error flag

module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              accept;
   logic              req_err;
   logic [IDX_W-1:0]  req_idx;

   assign accept  = req_valid && req_ready_q;
   assign req_idx = req_addr[IDX_W+1:2];
   // Range check uses all 30 word-address bits so high addresses never alias low words.
   assign req_err = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      we_d        = we_q;
      err_d       = err_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d = req_idx;
               we_d  = req_we;
               err_d = req_err;
               if (LATENCY == 1) begin
                  // No wait cycles: the read happens on the accepting edge itself.
                  state_d     = RESP;
                  rsp_rdata_d = (req_we || req_err) ? 32'h0 : mem_q[req_idx];
                  rsp_err_d   = req_err;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // Counter reaches 0 on this edge: this is the last WAIT cycle, so read now.
            if (cnt_q <= 4'd1) begin
               state_d     = RESP;
               cnt_d       = 4'd0;
               rsp_rdata_d = (we_q || err_q) ? 32'h0 : mem_q[idx_q];
               rsp_err_d   = err_q;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered handshake outputs follow the next state so req_ready rises on
      // the same edge that rsp_valid falls.
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= '0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         we_q        <= we_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Array is not reset; stores commit on the accepting edge when error-free.
   always_ff @(posedge clk) begin
      if (!rst && accept && req_we && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
               mem_q[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
